bldc_pwm_dt: RTL and testbench

- Next-generation six-output BLDC PWM and commutation generator with parametrised counter width.
- Adds edge- and center-aligned counting, shadowed period/duty registers that update only at period boundaries, dead-time blanking on commutation change, and a period-end strobe.
- Sits between the motor-control register block (configuration) and the gate-driver pins; pwm_middle_o feeds the zero-crossing/ADC sampling logic.

---
 rtl/bldc_pkg.sv | 53 +++++
 rtl/bldc_pwm_cnt.sv | 71 +++++++
 rtl/bldc_pwm_dt.sv | 112 +++++++++++
 tb/tb_bldc_pwm_dt.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bldc_pkg.sv
// Shared types and constants for the BLDC PWM / commutation generator:
// commutation step encodings, counting modes and the gate-drive bundle.
package bldc_pkg;

    localparam int CNT_W_DEF = 12;
    localparam int DT_W_DEF  = 8;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef enum logic [2:0] {
        COMM_OFF     = 3'b000,
        COMM_AP_BN   = 3'b001,
        COMM_AP_CN   = 3'b010,
        COMM_BP_CN   = 3'b011,
        COMM_BP_AN   = 3'b100,
        COMM_CP_AN   = 3'b101,
        COMM_CP_BN   = 3'b110,
        COMM_ALL_OFF = 3'b111
    } comm_e;

    typedef struct packed {
        logic pos_a;
        logic neg_a;
        logic pos_b;
        logic neg_b;
        logic pos_c;
        logic neg_c;
    } gate_t;

    // Only the selected high-side/low-side pair follows the PWM; a leg's pos and
    // neg are never both selected, so shoot-through is impossible by construction.
    function automatic gate_t comm_decode(input logic [2:0] step, input logic on);
        gate_t g;
        g = '0;
        case (step)
            COMM_AP_BN: begin g.pos_a = on; g.neg_b = on; end
            COMM_AP_CN: begin g.pos_a = on; g.neg_c = on; end
            COMM_BP_CN: begin g.pos_b = on; g.neg_c = on; end
            COMM_BP_AN: begin g.pos_b = on; g.neg_a = on; end
            COMM_CP_AN: begin g.pos_c = on; g.neg_a = on; end
            COMM_CP_BN: begin g.pos_c = on; g.neg_b = on; end
            default:    g = '0;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/bldc_pwm_cnt.sv
// PWM period counter: edge/center-aligned counting, shadowed period/duty/mode
// registers that reload only at a period boundary, and the boundary flag.
module bldc_pwm_cnt
    import bldc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             center_i,
    input  logic [CNT_W-1:0] period_i,
    input  logic [CNT_W-1:0] duty_i,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] period_sh,
    output logic [CNT_W-1:0] duty_sh,
    output logic             center_sh,
    output logic             boundary
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    dir_e dir;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        boundary = 1'b0;
        if (en) begin
            if (period_sh == '0)
                boundary = 1'b1;
            else if (center_sh == MODE_EDGE)
                boundary = (cnt == period_sh);
            else
                // P=1 never counts down through 1, so it closes on the way up
                boundary = (cnt == ONE) && ((dir == DIR_DOWN) || (period_sh == ONE));
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            dir       <= DIR_UP;
            period_sh <= '0;
            duty_sh   <= '0;
            center_sh <= MODE_EDGE;
        end else if (!en || boundary) begin
            cnt       <= '0;
            dir       <= DIR_UP;
            period_sh <= period_i;
            duty_sh   <= duty_i;
            center_sh <= center_i;
        end else if (center_sh == MODE_CENTER) begin
            if (dir == DIR_UP) begin
                if (cnt == period_sh) begin
                    dir <= DIR_DOWN;
                    cnt <= cnt - ONE;
                end else begin
                    cnt <= cnt + ONE;
                end
            end else begin
                cnt <= cnt - ONE;
            end
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/bldc_pwm_dt.sv
// Six-output BLDC PWM/commutation generator with dead-time blanking on step
// changes. Define BLDC_PWM_FAULT_EN to add the sticky fault shutdown input.
module bldc_pwm_dt
    import bldc_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DT_W  = DT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pwm_en_i,
    input  logic             center_i,
    input  logic [CNT_W-1:0] pwm_period_i,
    input  logic [CNT_W-1:0] pwm_duty_i,
    input  logic [2:0]       comm_i,
    input  logic [DT_W-1:0]  dt_i,
    output logic             pwm_posa_o,
    output logic             pwm_nega_o,
    output logic             pwm_posb_o,
    output logic             pwm_negb_o,
    output logic             pwm_posc_o,
    output logic             pwm_negc_o,
    output logic             pwm_middle_o,
    output logic             period_end_o
`ifdef BLDC_PWM_FAULT_EN
    ,
    input  logic             fault_i,
    input  logic             fault_clr_i,
    output logic             fault_o
`endif
);

    logic [CNT_W-1:0] cnt, period_sh, duty_sh;
    logic             center_sh, boundary;
    logic             pwm_on, mid_set, fault_active;
    logic [2:0]       comm_q;
    logic [DT_W-1:0]  dt_cnt;
    gate_t            gate_next, gate_q;
    logic             mid_q, period_end_q;

    bldc_pwm_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (pwm_en_i),
        .center_i  (center_i),
        .period_i  (pwm_period_i),
        .duty_i    (pwm_duty_i),
        .cnt       (cnt),
        .period_sh (period_sh),
        .duty_sh   (duty_sh),
        .center_sh (center_sh),
        .boundary  (boundary)
    );

`ifdef BLDC_PWM_FAULT_EN
    logic fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           fault_q <= 1'b0;
        else if (fault_i)     fault_q <= 1'b1;
        else if (fault_clr_i) fault_q <= 1'b0;
    end

    // The raw input also blocks, so the gates drop on the very next edge
    assign fault_active = fault_i | fault_q;
    assign fault_o      = fault_q;
`else
    assign fault_active = 1'b0;
`endif

    assign pwm_on  = pwm_en_i && (period_sh != '0) && (cnt < duty_sh);
    assign mid_set = (center_sh == MODE_CENTER) ? boundary : (cnt == (duty_sh >> 1));

    always_comb begin
        gate_next = comm_decode(comm_q, pwm_on);
        if ((dt_cnt != '0) || fault_active)
            gate_next = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            comm_q       <= 3'b000;
            dt_cnt       <= '0;
            gate_q       <= '0;
            mid_q        <= 1'b0;
            period_end_q <= 1'b0;
        end else begin
            comm_q       <= comm_i;
            gate_q       <= gate_next;
            period_end_q <= boundary;
            // A step change (re)starts blanking, even mid-blank
            if (comm_i != comm_q)
                dt_cnt <= dt_i;
            else if (dt_cnt != '0)
                dt_cnt <= dt_cnt - DT_W'(1);
            if (!pwm_on)
                mid_q <= 1'b0;
            else if (mid_set)
                mid_q <= 1'b1;
        end
    end

    assign pwm_posa_o   = gate_q.pos_a;
    assign pwm_nega_o   = gate_q.neg_a;
    assign pwm_posb_o   = gate_q.pos_b;
    assign pwm_negb_o   = gate_q.neg_b;
    assign pwm_posc_o   = gate_q.pos_c;
    assign pwm_negc_o   = gate_q.neg_c;
    assign pwm_middle_o = mid_q;
    assign period_end_o = period_end_q;

endmodule

// File: tb/tb_bldc_pwm_dt.sv
// Directed bench for bldc_pwm_dt: per-output bit histories are captured on the
// falling edge and compared with hand-derived patterns (bit i = sample i).
module tb_bldc_pwm_dt;

    logic        clk, rst_n, pwm_en_i, center_i;
    logic [11:0] pwm_period_i, pwm_duty_i;
    logic [2:0]  comm_i;
    logic [7:0]  dt_i;
    logic        pwm_posa_o, pwm_nega_o, pwm_posb_o, pwm_negb_o, pwm_posc_o, pwm_negc_o;
    logic        pwm_middle_o, period_end_o;
`ifdef BLDC_PWM_FAULT_EN
    logic        fault_i, fault_clr_i, fault_o;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] vec   [8];
    logic [31:0] exp_v [8];
    string       nm    [8];

    bldc_pwm_dt #(.CNT_W(12), .DT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pwm_en_i     (pwm_en_i),
        .center_i     (center_i),
        .pwm_period_i (pwm_period_i),
        .pwm_duty_i   (pwm_duty_i),
        .comm_i       (comm_i),
        .dt_i         (dt_i),
        .pwm_posa_o   (pwm_posa_o),
        .pwm_nega_o   (pwm_nega_o),
        .pwm_posb_o   (pwm_posb_o),
        .pwm_negb_o   (pwm_negb_o),
        .pwm_posc_o   (pwm_posc_o),
        .pwm_negc_o   (pwm_negc_o),
        .pwm_middle_o (pwm_middle_o),
        .period_end_o (period_end_o)
`ifdef BLDC_PWM_FAULT_EN
        ,
        .fault_i      (fault_i),
        .fault_clr_i  (fault_clr_i),
        .fault_o      (fault_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_vecs();
        for (int k = 0; k < 8; k++) vec[k] = '0;
    endtask

    task automatic sample_at(input int i);
        vec[0][i] = pwm_posa_o;
        vec[1][i] = pwm_nega_o;
        vec[2][i] = pwm_posb_o;
        vec[3][i] = pwm_negb_o;
        vec[4][i] = pwm_posc_o;
        vec[5][i] = pwm_negc_o;
        vec[6][i] = pwm_middle_o;
        vec[7][i] = period_end_o;
    endtask

    // Disable, load new settings (shadows follow while disabled), re-enable
    task automatic configure(input logic c, input int p, input int d,
                             input logic [2:0] cm, input int t);
        pwm_en_i     = 1'b0;
        center_i     = c;
        pwm_period_i = 12'(p);
        pwm_duty_i   = 12'(d);
        comm_i       = cm;
        dt_i         = 8'(t);
        step(8);
        pwm_en_i     = 1'b1;
    endtask

    task automatic wait_pe(input string tname);
        int n = 0;
        while (period_end_o !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (period_end_o !== 1'b1) begin
            $display("FAIL %s period_end timeout: got %b want 1", tname, period_end_o);
            failures++;
        end
    endtask

    task automatic test_reset();
        rst_n        = 1'b0;
        pwm_en_i     = 1'b1;
        center_i     = 1'b0;
        pwm_period_i = 12'd9;
        pwm_duty_i   = 12'd4;
        comm_i       = 3'b001;
        dt_i         = 8'd0;
        step(3);
        checks++;
        if ({pwm_posa_o, pwm_nega_o, pwm_posb_o, pwm_negb_o, pwm_posc_o, pwm_negc_o,
             pwm_middle_o, period_end_o} !== 8'h00) begin
            $display("FAIL reset outputs: got %b%b%b%b%b%b%b%b want 00000000",
                     pwm_posa_o, pwm_nega_o, pwm_posb_o, pwm_negb_o, pwm_posc_o,
                     pwm_negc_o, pwm_middle_o, period_end_o);
            failures++;
        end
        checks++;
        if (dut.u_cnt.cnt !== 12'd0) begin
            $display("FAIL reset cnt: got %0d want 0", dut.u_cnt.cnt);
            failures++;
        end
        pwm_en_i = 1'b0;
        rst_n    = 1'b1;
        step(2);
    endtask

    task automatic test_edge();
        configure(1'b0, 9, 4, 3'b001, 0);
        wait_pe("edge");
        clear_vecs();
        for (int i = 0; i < 20; i++) begin
            sample_at(i);
            step(1);
        end
        exp_v = '{32'h781E, 32'h0, 32'h0, 32'h781E, 32'h0, 32'h0, 32'h6018, 32'h401};
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (vec[k] !== exp_v[k]) begin
                $display("FAIL edge %s: got %h want %h", nm[k], vec[k], exp_v[k]);
                failures++;
            end
        end
    endtask

    task automatic test_center();
        configure(1'b1, 8, 3, 3'b001, 0);
        wait_pe("center");
        clear_vecs();
        for (int i = 0; i < 16; i++) begin
            sample_at(i);
            step(1);
        end
        exp_v = '{32'h800F, 32'h0, 32'h0, 32'h800F, 32'h0, 32'h0, 32'h000F, 32'h0001};
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (vec[k] !== exp_v[k]) begin
                $display("FAIL center %s: got %h want %h", nm[k], vec[k], exp_v[k]);
                failures++;
            end
        end
    endtask

    task automatic test_duty_shadow();
        configure(1'b0, 9, 4, 3'b001, 0);
        wait_pe("duty_shadow");
        clear_vecs();
        for (int i = 0; i < 20; i++) begin
            if (i == 3) pwm_duty_i = 12'd7;
            sample_at(i);
            step(1);
        end
        exp_v = '{32'h3F81E, 32'h0, 32'h0, 32'h3F81E, 32'h0, 32'h0, 32'h3C018, 32'h401};
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (vec[k] !== exp_v[k]) begin
                $display("FAIL duty_shadow %s: got %h want %h", nm[k], vec[k], exp_v[k]);
                failures++;
            end
        end
    endtask

    task automatic test_duty_limits();
        configure(1'b0, 9, 0, 3'b001, 0);
        wait_pe("duty_zero");
        clear_vecs();
        for (int i = 0; i < 20; i++) begin
            sample_at(i);
            step(1);
        end
        exp_v = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h401};
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (vec[k] !== exp_v[k]) begin
                $display("FAIL duty_zero %s: got %h want %h", nm[k], vec[k], exp_v[k]);
                failures++;
            end
        end
        configure(1'b0, 9, 15, 3'b001, 0);
        wait_pe("duty_full");
        clear_vecs();
        for (int i = 0; i < 20; i++) begin
            sample_at(i);
            step(1);
        end
        exp_v = '{32'hFFFFF, 32'h0, 32'h0, 32'hFFFFF, 32'h0, 32'h0, 32'hFFFFF, 32'h401};
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (vec[k] !== exp_v[k]) begin
                $display("FAIL duty_full %s: got %h want %h", nm[k], vec[k], exp_v[k]);
                failures++;
            end
        end
    endtask

    task automatic test_period_zero();
        configure(1'b0, 0, 4, 3'b001, 0);
        step(2);
        clear_vecs();
        for (int i = 0; i < 10; i++) begin
            sample_at(i);
            step(1);
        end
        exp_v = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3FF};
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (vec[k] !== exp_v[k]) begin
                $display("FAIL period_zero %s: got %h want %h", nm[k], vec[k], exp_v[k]);
                failures++;
            end
        end
    endtask

    task automatic test_enable_low();
        configure(1'b0, 9, 4, 3'b001, 0);
        wait_pe("enable_low");
        step(3);
        checks++;
        if ({pwm_posa_o, pwm_negb_o, pwm_middle_o} !== 3'b111) begin
            $display("FAIL enable_low before: got %b%b%b want 111",
                     pwm_posa_o, pwm_negb_o, pwm_middle_o);
            failures++;
        end
        pwm_en_i = 1'b0;
        step(1);
        checks++;
        if ({pwm_posa_o, pwm_negb_o, pwm_middle_o, period_end_o} !== 4'b0000) begin
            $display("FAIL enable_low outputs: got %b%b%b%b want 0000",
                     pwm_posa_o, pwm_negb_o, pwm_middle_o, period_end_o);
            failures++;
        end
        checks++;
        if (dut.u_cnt.cnt !== 12'd0) begin
            $display("FAIL enable_low cnt: got %0d want 0", dut.u_cnt.cnt);
            failures++;
        end
    endtask

    task automatic test_dead_time();
        configure(1'b0, 9, 15, 3'b001, 5);
        wait_pe("dead_time");
        step(2);
        clear_vecs();
        for (int j = 0; j < 12; j++) begin
            if (j == 0) comm_i = 3'b011;
            sample_at(j);
            step(1);
        end
        exp_v = '{32'h3, 32'h0, 32'hF80, 32'h3, 32'h0, 32'hF80, 32'hFFF, 32'h100};
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (vec[k] !== exp_v[k]) begin
                $display("FAIL dead_time %s: got %h want %h", nm[k], vec[k], exp_v[k]);
                failures++;
            end
        end
    endtask

    task automatic test_back_to_back();
        configure(1'b0, 9, 15, 3'b001, 5);
        wait_pe("dt_restart");
        step(2);
        clear_vecs();
        for (int j = 0; j < 14; j++) begin
            if (j == 0) comm_i = 3'b011;
            if (j == 2) comm_i = 3'b010;
            sample_at(j);
            step(1);
        end
        exp_v = '{32'h3E03, 32'h0, 32'h0, 32'h3, 32'h0, 32'h3E00, 32'h3FFF, 32'h100};
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (vec[k] !== exp_v[k]) begin
                $display("FAIL dt_restart %s: got %h want %h", nm[k], vec[k], exp_v[k]);
                failures++;
            end
        end
    endtask

`ifdef BLDC_PWM_FAULT_EN
    task automatic test_fault();
        configure(1'b0, 9, 15, 3'b001, 0);
        wait_pe("fault");
        step(2);
        checks++;
        if ({pwm_posa_o, fault_o} !== 2'b10) begin
            $display("FAIL fault idle: got posa=%b fault=%b want 1 0", pwm_posa_o, fault_o);
            failures++;
        end
        fault_i = 1'b1;
        step(1);
        checks++;
        if ({pwm_posa_o, pwm_negb_o, fault_o} !== 3'b001) begin
            $display("FAIL fault trip: got %b%b%b want 001", pwm_posa_o, pwm_negb_o, fault_o);
            failures++;
        end
        fault_clr_i = 1'b1;
        step(1);
        checks++;
        if (fault_o !== 1'b1) begin
            $display("FAIL fault clr_blocked: got %b want 1", fault_o);
            failures++;
        end
        fault_i     = 1'b0;
        fault_clr_i = 1'b0;
        step(2);
        checks++;
        if ({pwm_posa_o, fault_o} !== 2'b01) begin
            $display("FAIL fault sticky: got posa=%b fault=%b want 0 1", pwm_posa_o, fault_o);
            failures++;
        end
        fault_clr_i = 1'b1;
        step(1);
        fault_clr_i = 1'b0;
        checks++;
        if ({pwm_posa_o, fault_o} !== 2'b00) begin
            $display("FAIL fault clear: got posa=%b fault=%b want 0 0", pwm_posa_o, fault_o);
            failures++;
        end
        step(1);
        checks++;
        if ({pwm_posa_o, pwm_negb_o} !== 2'b11) begin
            $display("FAIL fault resume: got %b%b want 11", pwm_posa_o, pwm_negb_o);
            failures++;
        end
    endtask
`endif

    initial begin
        nm = '{"posa", "nega", "posb", "negb", "posc", "negc", "middle", "period_end"};
`ifdef BLDC_PWM_FAULT_EN
        fault_i     = 1'b0;
        fault_clr_i = 1'b0;
`endif
        test_reset();
        test_edge();
        test_center();
        test_duty_shadow();
        test_duty_limits();
        test_period_zero();
        test_enable_low();
        test_dead_time();
        test_back_to_back();
`ifdef BLDC_PWM_FAULT_EN
        test_fault();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
